// File: rtl/alu_share_arb_if.sv
// ============================================================================
// Module   : alu_share_arb_if
// Purpose  : Bundles the request, ALU and response signals of the shared-ALU
//            arbiter. The slave modport is the arbiter's view. The master
//            modport is the view of the requesters and the ALU.
//            The rsp_err signal exists only when ALU_ARB_OPCHK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_share_arb_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [2:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [2:0]       req1_op;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             alu_sign;

    logic             rsp_valid;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_sign;
    logic             rsp_ready;
    logic             busy;
`ifdef ALU_ARB_OPCHK_EN
    logic             rsp_err;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  alu_result, alu_zero, alu_sign, rsp_ready,
        output req0_ready, req1_ready, alu_a, alu_b, alu_ctrl,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_sign, busy, rsp_err
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output alu_result, alu_zero, alu_sign, rsp_ready,
        input  req0_ready, req1_ready, alu_a, alu_b, alu_ctrl,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_sign, busy, rsp_err
    );
`else
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  alu_result, alu_zero, alu_sign, rsp_ready,
        output req0_ready, req1_ready, alu_a, alu_b, alu_ctrl,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_sign, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output alu_result, alu_zero, alu_sign, rsp_ready,
        input  req0_ready, req1_ready, alu_a, alu_b, alu_ctrl,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_sign, busy
    );
`endif

endinterface

`default_nettype wire

// File: rtl/alu_share_arb.sv
// ============================================================================
// Module   : alu_share_arb
// Purpose  : Shares one ALU between two requesters. It grants one operation
//            at a time and drives the ALU for a single EXEC cycle. It then
//            returns the registered result and flags to the owner of the
//            operation through a valid/ready response.
// Options  : ALU_ARB_OPCHK_EN - reject opcode 011 without using the ALU. The
//            response carries rsp_err=1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_share_arb #(
    parameter int WIDTH      = 32,
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_share_arb_if.slave      bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

`ifdef ALU_ARB_OPCHK_EN
    localparam logic [2:0] c_op_undef = 3'b011;
`endif

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_rr;
    logic             r_owner;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_sign;
`ifdef ALU_ARB_OPCHK_EN
    logic             r_err;
`endif

    logic             w_any_valid;
    logic             w_gnt_id;
    logic             w_grant;
    logic [WIDTH-1:0] w_gnt_a;
    logic [WIDTH-1:0] w_gnt_b;
    logic [2:0]       w_gnt_op;
    logic             w_exec;

    assign w_any_valid = bus.req0_valid | bus.req1_valid;

    // Arbitration. A lone valid requester always wins. A tie goes either to
    // requester 0 (fixed) or to the requester named by the rr pointer.
    generate
        if (PRIO_FIXED) begin : g_prio_fixed
            assign w_gnt_id = ~bus.req0_valid;
        end else begin : g_prio_rr
            assign w_gnt_id = (bus.req0_valid & bus.req1_valid) ? r_rr : bus.req1_valid;
        end
    endgenerate

    assign w_gnt_a  = w_gnt_id ? bus.req1_a  : bus.req0_a;
    assign w_gnt_b  = w_gnt_id ? bus.req1_b  : bus.req0_b;
    assign w_gnt_op = w_gnt_id ? bus.req1_op : bus.req0_op;

    // State register; an asserted reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and grant. Requests are only accepted in IDLE, and
    // never while reset is asserted, so that all outputs read 0 during reset.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_exec      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_valid && rst_n) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_EXEC;
`ifdef ALU_ARB_OPCHK_EN
                    if (w_gnt_op == c_op_undef) begin
                        w_state_nxt = S_RESP;
                    end
`endif
                end
            end
            S_EXEC: begin
                w_exec      = 1'b1;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand latch on grant, result capture after EXEC, rr update on a
    // completed response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr     <= 1'b0;
            r_owner  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 3'b000;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_sign   <= 1'b0;
`ifdef ALU_ARB_OPCHK_EN
            r_err    <= 1'b0;
`endif
        end else begin
            if (w_grant) begin
                r_a     <= w_gnt_a;
                r_b     <= w_gnt_b;
                r_op    <= w_gnt_op;
                r_owner <= w_gnt_id;
`ifdef ALU_ARB_OPCHK_EN
                // An illegal op bypasses the ALU, so its response is built here.
                if (w_gnt_op == c_op_undef) begin
                    r_result <= '0;
                    r_zero   <= 1'b1;
                    r_sign   <= 1'b0;
                    r_err    <= 1'b1;
                end
`endif
            end
            if (w_exec) begin
                r_result <= bus.alu_result;
                r_zero   <= bus.alu_zero;
                r_sign   <= bus.alu_sign;
`ifdef ALU_ARB_OPCHK_EN
                r_err    <= 1'b0;
`endif
            end
            if ((r_state == S_RESP) && bus.rsp_ready && (PRIO_FIXED == 1'b0)) begin
                r_rr <= ~r_owner;
            end
        end
    end

    assign bus.req0_ready = w_grant & ~w_gnt_id;
    assign bus.req1_ready = w_grant &  w_gnt_id;

    assign bus.alu_a      = w_exec ? r_a  : '0;
    assign bus.alu_b      = w_exec ? r_b  : '0;
    assign bus.alu_ctrl   = w_exec ? r_op : 3'b000;

    assign bus.rsp_valid  = (r_state == S_RESP);
    assign bus.rsp_id     = r_owner;
    assign bus.rsp_result = r_result;
    assign bus.rsp_zero   = r_zero;
    assign bus.rsp_sign   = r_sign;
    assign bus.busy       = (r_state != S_IDLE);
`ifdef ALU_ARB_OPCHK_EN
    assign bus.rsp_err    = r_err;
`endif

endmodule

`default_nettype wire
